pool2x2_fixed: RTL and testbench

- Streaming 2x2 stride-2 max-pooling stage, directly downstream of the 3-layer feature extractor.
- Consumes its multi-unit signed fixed-point feature stream with raster counters. Emits one pooled feature vector per 2x2 block, with an enable strobe and delayed counters.
- Uses a single half-width line buffer, so the extractor output can feed a lower-resolution segmentation head without a frame buffer.

---
 rtl/pool2x2_fixed.sv | 151 +++++++++++++++
 tb/tb_pool2x2_fixed.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/pool2x2_fixed.sv
`default_nettype none
// ============================================================================
//  Module   : pool2x2_fixed
//  Purpose  : Streaming 2x2 stride-2 max-pooling stage for a multi-unit
//             signed fixed-point feature stream. Horizontal pairs are
//             reduced in stage 1. Even-row results are parked in a
//             half-width line buffer and merged with the odd row in stage 2.
//  Options  : define POOL_RELU_EN to clamp negative pooled units to zero.
//  Revision : 1.0  initial release
// ============================================================================
module pool2x2_fixed #(
  parameter int WIDTH      = 4,
  parameter int HEIGHT     = 4,
  parameter int W_WIDTH    = 6,
  parameter int W_HEIGHT   = 6,
  parameter int UNITS      = 12,
  parameter int INT_BITW   = 5,
  parameter int FRAC_BITW  = 8,
  parameter int FIXED_BITW = INT_BITW + FRAC_BITW,
  parameter int H_BITW     = $clog2(W_WIDTH),
  parameter int V_BITW     = $clog2(W_HEIGHT)
) (
  input  logic                        clock,
  input  logic                        n_rst,
  input  logic                        in_enable,
  input  logic [0:FIXED_BITW*UNITS-1] in_pixels,
  input  logic [V_BITW-1:0]           in_vcnt,
  input  logic [H_BITW-1:0]           in_hcnt,
  output logic                        out_enable,
  output logic [0:FIXED_BITW*UNITS-1] out_pixels,
  output logic [V_BITW-1:0]           out_vcnt,
  output logic [H_BITW-1:0]           out_hcnt
);

  localparam int c_vec_w  = FIXED_BITW * UNITS;
  // One entry per column pair; an odd trailing column never pairs.
  localparam int c_depth  = (WIDTH + 1) / 2;
  localparam int c_addr_w = (c_depth > 1) ? $clog2(c_depth) : 1;
  localparam logic [H_BITW-1:0] c_width_lim  = H_BITW'(WIDTH);
  localparam logic [V_BITW-1:0] c_height_lim = V_BITW'(HEIGHT);

  // Input qualification
  logic                 active;

  // Stage 1 state
  logic [0:c_vec_w-1]   pair_q;
  logic [0:c_vec_w-1]   hmax_q;
  logic                 hvalid_q;
  logic [H_BITW-1:0]    s1_hcnt;
  logic [V_BITW-1:0]    s1_vcnt;

  // Combinational reductions
  logic [0:c_vec_w-1]   hmax_d;
  logic [0:c_vec_w-1]   pool_d;

  // Line buffer and stage 2 controls
  logic [0:c_vec_w-1]   line_mem [c_depth];
  logic [c_addr_w-1:0]  buf_addr;
  logic [0:c_vec_w-1]   buf_rd;
  logic                 wr_en;
  logic                 rd_en;
  logic                 line_ok;

  assign active = in_enable && (in_hcnt < c_width_lim) && (in_vcnt < c_height_lim);

  // Column pair index of the stage-1 pixel addresses the line buffer.
  assign buf_addr = s1_hcnt[c_addr_w:1];
  assign buf_rd   = line_mem[buf_addr];
  assign wr_en    = hvalid_q && !s1_vcnt[0];
  assign rd_en    = hvalid_q &&  s1_vcnt[0];

  // Per-unit signed comparators; ties keep the earlier (pair / buffered) value.
  for (genvar u = 0; u < UNITS; u++) begin : g_unit
    logic signed [FIXED_BITW-1:0] pair_u;
    logic signed [FIXED_BITW-1:0] cur_u;
    logic signed [FIXED_BITW-1:0] hmax_u;
    logic signed [FIXED_BITW-1:0] buf_u;
    logic signed [FIXED_BITW-1:0] max_u;
    logic signed [FIXED_BITW-1:0] res_u;

    assign pair_u = pair_q[u*FIXED_BITW +: FIXED_BITW];
    assign cur_u  = in_pixels[u*FIXED_BITW +: FIXED_BITW];
    assign hmax_u = hmax_q[u*FIXED_BITW +: FIXED_BITW];
    assign buf_u  = buf_rd[u*FIXED_BITW +: FIXED_BITW];

    assign hmax_d[u*FIXED_BITW +: FIXED_BITW] = (pair_u >= cur_u) ? pair_u : cur_u;
    assign max_u = (buf_u >= hmax_u) ? buf_u : hmax_u;

`ifdef POOL_RELU_EN
    assign res_u = max_u[FIXED_BITW-1] ? '0 : max_u;
`else
    assign res_u = max_u;
`endif

    assign pool_d[u*FIXED_BITW +: FIXED_BITW] = res_u;
  end : g_unit

  // Stage 1: capture even-column pixel, reduce with odd-column pixel.
  always_ff @(posedge clock) begin
    if (!n_rst) begin
      pair_q   <= '0;
      hmax_q   <= '0;
      hvalid_q <= 1'b0;
      s1_hcnt  <= '0;
      s1_vcnt  <= '0;
    end else begin
      s1_hcnt  <= in_hcnt;
      s1_vcnt  <= in_vcnt;
      hvalid_q <= active && in_hcnt[0];
      if (active && !in_hcnt[0]) begin
        pair_q <= in_pixels;
      end
      if (active && in_hcnt[0]) begin
        hmax_q <= hmax_d;
      end
    end
  end

  // Line buffer: even-row horizontal maxima, contents intentionally not reset.
  always_ff @(posedge clock) begin
    if (n_rst && wr_en) begin
      line_mem[buf_addr] <= hmax_q;
    end
  end

  // Stage 2: merge odd row with buffered even row, gate on a trusted buffer.
  always_ff @(posedge clock) begin
    if (!n_rst) begin
      out_enable <= 1'b0;
      out_pixels <= '0;
      out_vcnt   <= '0;
      out_hcnt   <= '0;
      line_ok    <= 1'b0;
    end else begin
      out_vcnt <= s1_vcnt;
      out_hcnt <= s1_hcnt;
      // Writing pair 0 of an even row means the buffer now holds a fresh row.
      if (wr_en && (buf_addr == '0)) begin
        line_ok <= 1'b1;
      end
      if (rd_en && line_ok) begin
        out_enable <= 1'b1;
        out_pixels <= pool_d;
      end else begin
        out_enable <= 1'b0;
      end
    end
  end

endmodule : pool2x2_fixed
`default_nettype wire

// File: tb/tb_pool2x2_fixed.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pool2x2_fixed
//  Purpose  : Directed self-checking bench for pool2x2_fixed. Drives 6x6
//             raster frames into a 4x4 and a 5x5 active-area instance and
//             checks strobe count, counts, latency and pooled values.
//  Options  : honours POOL_RELU_EN for the expected values.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pool2x2_fixed;

  localparam int FB = 13;
  localparam int VW = 2 * FB;

  typedef struct {
    int             cyc;
    int             h;
    int             v;
    logic [0:VW-1]  pix;
  } strobe_t;

  logic            clock;
  logic            n_rst;
  logic            in_enable;
  logic [0:VW-1]   in_pixels;
  logic [2:0]      in_vcnt;
  logic [2:0]      in_hcnt;

  logic            out_enable4, out_enable5;
  logic [0:VW-1]   out_pixels4, out_pixels5;
  logic [2:0]      out_vcnt4, out_vcnt5;
  logic [2:0]      out_hcnt4, out_hcnt5;

  int              n_cmp = 0;
  int              n_bad = 0;
  int              cyc   = 0;

  strobe_t         q4[$];
  strobe_t         q5[$];
  logic [0:VW-1]   pix [6][6];
  logic            en  [6][6];
  int              drive_cyc [6][6];

  pool2x2_fixed #(
    .WIDTH(4), .HEIGHT(4), .W_WIDTH(6), .W_HEIGHT(6),
    .UNITS(2), .INT_BITW(5), .FRAC_BITW(8)
  ) dut4 (
    .clock(clock), .n_rst(n_rst), .in_enable(in_enable), .in_pixels(in_pixels),
    .in_vcnt(in_vcnt), .in_hcnt(in_hcnt), .out_enable(out_enable4),
    .out_pixels(out_pixels4), .out_vcnt(out_vcnt4), .out_hcnt(out_hcnt4)
  );

  pool2x2_fixed #(
    .WIDTH(5), .HEIGHT(5), .W_WIDTH(6), .W_HEIGHT(6),
    .UNITS(2), .INT_BITW(5), .FRAC_BITW(8)
  ) dut5 (
    .clock(clock), .n_rst(n_rst), .in_enable(in_enable), .in_pixels(in_pixels),
    .in_vcnt(in_vcnt), .in_hcnt(in_hcnt), .out_enable(out_enable5),
    .out_pixels(out_pixels5), .out_vcnt(out_vcnt5), .out_hcnt(out_hcnt5)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Rising-edge cycle count used to time-stamp inputs and strobes.
  always @(posedge clock) cyc <= cyc + 1;

  // Collect strobes of both instances away from the active edge.
  always @(negedge clock) begin
    strobe_t s;
    if (out_enable4) begin
      s.cyc = cyc; s.h = int'(out_hcnt4); s.v = int'(out_vcnt4); s.pix = out_pixels4;
      q4.push_back(s);
    end
    if (out_enable5) begin
      s.cyc = cyc; s.h = int'(out_hcnt5); s.v = int'(out_vcnt5); s.pix = out_pixels5;
      q5.push_back(s);
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [FB-1:0] rl(input logic [FB-1:0] x);
`ifdef POOL_RELU_EN
    return x[FB-1] ? '0 : x;
`else
    return x;
`endif
  endfunction

  function automatic logic [0:VW-1] vec(input logic [FB-1:0] a, input logic [FB-1:0] b);
    return {a, b};
  endfunction

  // Compare strobe i of one instance against its counts, value and latency.
  task automatic check_strobe(input string tag, input bit use5, input int i,
                              input int eh, input int ev, input logic [0:VW-1] epix);
    strobe_t s;
    int n;
    n = use5 ? q5.size() : q4.size();
    if (i >= n) begin
      check_eq({tag, "_missing"}, 64'(n), 64'(i + 1));
    end else begin
      s = use5 ? q5[i] : q4[i];
      check_eq({tag, "_hcnt"}, 64'(s.h), 64'(eh));
      check_eq({tag, "_vcnt"}, 64'(s.v), 64'(ev));
      check_eq({tag, "_pix"},  64'(s.pix), 64'(epix));
      check_eq({tag, "_lat"},  64'(s.cyc), 64'(drive_cyc[ev][eh] + 2));
    end
  endtask

  // One full 6x6 raster frame; reset is pulsed for one cycle at (rv,rh).
  task automatic run_frame(input int rv, input int rh);
    bit rst_chk;
    rst_chk = 1'b0;
    q4.delete();
    q5.delete();
    for (int v = 0; v < 6; v++) begin
      for (int h = 0; h < 6; h++) begin
        @(negedge clock);
        if (rst_chk) begin
          check_eq("rst_mid_en",   64'(out_enable4), 64'd0);
          check_eq("rst_mid_pix",  64'(out_pixels4), 64'd0);
          check_eq("rst_mid_hcnt", 64'(out_hcnt4),   64'd0);
          check_eq("rst_mid_vcnt", 64'(out_vcnt4),   64'd0);
          rst_chk = 1'b0;
        end
        n_rst     = !(v == rv && h == rh);
        rst_chk   = (v == rv && h == rh);
        in_vcnt   = 3'(v);
        in_hcnt   = 3'(h);
        in_enable = en[v][h];
        in_pixels = pix[v][h];
        drive_cyc[v][h] = cyc;
      end
    end
  endtask

  task automatic fill(input logic [0:VW-1] p);
    for (int v = 0; v < 6; v++)
      for (int h = 0; h < 6; h++) begin
        pix[v][h] = p;
        en[v][h]  = 1'b1;
      end
  endtask

  task automatic fill_ramp();
    logic [FB-1:0] a;
    fill('0);
    for (int v = 0; v < 6; v++)
      for (int h = 0; h < 6; h++) begin
        a = FB'((h + 4 * v) * 256);
        pix[v][h] = vec(a, -a);
      end
  endtask

  initial begin
    n_rst = 1'b0; in_enable = 1'b0; in_pixels = '0; in_vcnt = '0; in_hcnt = '0;
    repeat (3) @(negedge clock);
    check_eq("rst_en",   64'(out_enable4), 64'd0);
    check_eq("rst_pix",  64'(out_pixels4), 64'd0);
    check_eq("rst_hcnt", 64'(out_hcnt4),   64'd0);
    check_eq("rst_vcnt", 64'(out_vcnt4),   64'd0);
    n_rst = 1'b1;

    // Ramp: unit0 = h+4v, unit1 = its negation.
    fill_ramp();
    run_frame(-1, -1);
    check_eq("ramp_n", 64'(q4.size()), 64'd4);
    check_strobe("ramp_b00", 0, 0, 1, 1, vec(13'h0500, rl(13'h0000)));
    check_strobe("ramp_b10", 0, 1, 3, 1, vec(13'h0700, rl(13'h1E00)));
    check_strobe("ramp_b01", 0, 2, 1, 3, vec(13'h0D00, rl(13'h1800)));
    check_strobe("ramp_b11", 0, 3, 3, 3, vec(13'h0F00, rl(13'h1600)));

    // All pixels -1.5.
    fill(vec(13'h1E80, 13'h1E80));
    run_frame(-1, -1);
    check_eq("neg_n", 64'(q4.size()), 64'd4);
    check_strobe("neg_b00", 0, 0, 1, 1, vec(rl(13'h1E80), rl(13'h1E80)));
    check_strobe("neg_b11", 0, 3, 3, 3, vec(rl(13'h1E80), rl(13'h1E80)));

    // Single 3.25 among -4.0 at each position of block (0,0).
    for (int k = 0; k < 4; k++) begin
      fill(vec(13'h1C00, 13'h1C00));
      pix[k / 2][k % 2] = vec(13'h0340, 13'h0340);
      run_frame(-1, -1);
      check_strobe($sformatf("single%0d", k), 0, 0, 1, 1, vec(13'h0340, 13'h0340));
    end

    // Pixel (1,1) disabled: block (0,0) never strobes.
    fill_ramp();
    en[1][1] = 1'b0;
    run_frame(-1, -1);
    check_eq("gap_n", 64'(q4.size()), 64'd3);
    check_strobe("gap_b10", 0, 0, 3, 1, vec(13'h0700, rl(13'h1E00)));
    check_strobe("gap_b01", 0, 1, 1, 3, vec(13'h0D00, rl(13'h1800)));
    check_strobe("gap_b11", 0, 2, 3, 3, vec(13'h0F00, rl(13'h1600)));

    // Reset pulse at vcnt=1, hcnt=2: row pair 0/1 lost, rows 2/3 pool normally.
    fill_ramp();
    run_frame(1, 2);
    n_rst = 1'b1;
    check_eq("mrst_n", 64'(q4.size()), 64'd2);
    check_strobe("mrst_b01", 0, 0, 1, 3, vec(13'h0D00, rl(13'h1800)));
    check_strobe("mrst_b11", 0, 1, 3, 3, vec(13'h0F00, rl(13'h1600)));

    // 5x5 instance: column 4 and line 4 carry 15.0 and must never surface.
    fill(vec(13'h0100, 13'h0100));
    for (int k = 0; k < 5; k++) begin
      pix[k][4] = vec(13'h0F00, 13'h0F00);
      pix[4][k] = vec(13'h0F00, 13'h0F00);
    end
    run_frame(-1, -1);
    check_eq("odd_n", 64'(q5.size()), 64'd4);
    check_strobe("odd_b00", 1, 0, 1, 1, vec(13'h0100, 13'h0100));
    check_strobe("odd_b10", 1, 1, 3, 1, vec(13'h0100, 13'h0100));
    check_strobe("odd_b01", 1, 2, 1, 3, vec(13'h0100, 13'h0100));
    check_strobe("odd_b11", 1, 3, 3, 3, vec(13'h0100, 13'h0100));

    @(negedge clock);
    in_enable = 1'b0;
    repeat (4) @(negedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_pool2x2_fixed
`default_nettype wire
